pckcfg_seq: RTL and testbench

PCKCFG_SEQ -- requirements
Module: pckcfg_seq

---
 rtl/pckcfg_seq.sv | 142 ++++++++++++++
 tb/tb_pckcfg_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pckcfg_seq.sv
// MMCM pixel-clock reconfiguration sequencer: walks a per-mode DRP table
// (read-modify-write per entry) under MMCM reset, then waits for lock.
module pckcfg_seq #(
  parameter int NREG     = 8,
  parameter int DRDY_TMO = 255,
  parameter int LOCK_TMO = 65535
) (
  input  logic        SYSCLK,
  input  logic        RSTN,
  input  logic        REQ,
  input  logic [1:0]  MODE,
  output logic [5:0]  TBL_ADDR,
  input  logic [38:0] TBL_DATA,
  output logic [6:0]  DADDR,
  output logic [15:0] DI,
  output logic        DEN,
  output logic        DWE,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        MMCM_RST,
  input  logic        LOCKED,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);
  localparam int DW = $clog2(DRDY_TMO + 1);
  localparam int LW = $clog2(LOCK_TMO + 1);

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
  } tbl_t;

  typedef enum logic [3:0] {
    IDLE, RST, FETCH, RD, RD_WAIT, WR, WR_WAIT, REL, LOCK_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    mode_q;
  logic [3:0]    entry_q;
  logic          last_q;
  tbl_t          ent_q;
  logic [15:0]   di_q;
  logic [DW-1:0] dcnt_q;
  logic [LW-1:0] lcnt_q;
  logic [1:0]    lk_sync;
  logic [1:0]    rdy_pipe;
  logic          err_q, done_q;

  logic accept, reject, in_wait, drdy_tmo, lock_tmo;

  always_comb begin
    accept   = (state == IDLE) && rdy_pipe[1] && REQ && (MODE != 2'd3);
    reject   = (state == IDLE) && rdy_pipe[1] && REQ && (MODE == 2'd3);
    in_wait  = (state == RD_WAIT) || (state == WR_WAIT);
    drdy_tmo = (dcnt_q == DW'(DRDY_TMO - 1));
    lock_tmo = (lcnt_q == LW'(LOCK_TMO - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = RST;
      RST:       state_nxt = FETCH;
      FETCH:     state_nxt = RD;
      RD:        state_nxt = RD_WAIT;
      RD_WAIT:   if (DRDY) state_nxt = WR;
                 else if (drdy_tmo) state_nxt = IDLE;
      WR:        state_nxt = WR_WAIT;
      WR_WAIT:   if (DRDY) state_nxt = last_q ? REL : FETCH;
                 else if (drdy_tmo) state_nxt = IDLE;
      REL:       state_nxt = LOCK_WAIT;
      LOCK_WAIT: if (lk_sync[1] || lock_tmo) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge SYSCLK or negedge RSTN) begin
    if (!RSTN) begin
      mode_q   <= '0;
      entry_q  <= '0;
      last_q   <= 1'b0;
      ent_q    <= '0;
      di_q     <= '0;
      dcnt_q   <= '0;
      lcnt_q   <= '0;
      lk_sync  <= '0;
      rdy_pipe <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rdy_pipe <= {rdy_pipe[0], 1'b1};
      lk_sync  <= {lk_sync[0], LOCKED};
      done_q   <= 1'b0;
      if (accept) begin
        mode_q  <= MODE;
        entry_q <= '0;
        last_q  <= 1'b0;
        err_q   <= 1'b0;
      end
      if (reject) err_q <= 1'b1;
      if (state == FETCH) ent_q <= tbl_t'(TBL_DATA);
      if (state == RD_WAIT && DRDY)
        di_q <= (DO & ent_q.mask) | (ent_q.data & ~ent_q.mask);
      // ROM has one cycle of latency, so the next entry address is
      // advanced in WR and is already stable through WR_WAIT.
      if (state == WR) begin
        last_q <= (entry_q == 4'(NREG - 1));
        if (entry_q != 4'(NREG - 1)) entry_q <= entry_q + 4'd1;
      end
      if (state == RD || state == WR) dcnt_q <= '0;
      else if (in_wait && !DRDY)      dcnt_q <= dcnt_q + 1'b1;
      if (in_wait && !DRDY && drdy_tmo) err_q <= 1'b1;
      if (state == REL)            lcnt_q <= '0;
      else if (state == LOCK_WAIT) lcnt_q <= lcnt_q + 1'b1;
      if (state == LOCK_WAIT) begin
        if (lk_sync[1])    done_q <= 1'b1;
        else if (lock_tmo) err_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    TBL_ADDR = {mode_q, entry_q};
    DADDR    = ent_q.addr;
    DI       = di_q;
    DEN      = (state == RD) || (state == WR);
    DWE      = (state == WR);
    MMCM_RST = (state == RST) || (state == FETCH) || (state == RD) ||
               (state == RD_WAIT) || (state == WR) || (state == WR_WAIT);
    BUSY     = (state != IDLE);
    DONE     = done_q;
    ERR      = err_q;
  end

endmodule

// File: tb/tb_pckcfg_seq.sv
// Scoreboard bench for pckcfg_seq: ROM, DRP slave and MMCM lock models.
module tb_pckcfg_seq;
  localparam int NREG = 8;

  logic        SYSCLK = 1'b0, RSTN = 1'b0, REQ = 1'b0;
  logic [1:0]  MODE = 2'd0;
  logic [5:0]  TBL_ADDR;
  logic [38:0] TBL_DATA = '0;
  logic [6:0]  DADDR;
  logic [15:0] DI, DO = '0;
  logic        DEN, DWE, DRDY = 1'b0, MMCM_RST, LOCKED = 1'b0, BUSY, DONE, ERR;

  pckcfg_seq #(.NREG(NREG), .DRDY_TMO(255), .LOCK_TMO(1000)) dut (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .REQ(REQ), .MODE(MODE),
    .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA), .DADDR(DADDR), .DI(DI),
    .DEN(DEN), .DWE(DWE), .DO(DO), .DRDY(DRDY), .MMCM_RST(MMCM_RST),
    .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct { logic we; logic [6:0] addr; logic [15:0] di; } sb_t;
  sb_t sb_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_done = 0, n_den = 0, rd_cnt = 0, wr_cnt = 0, hang_rd = 0;
  int t_den3 = 0, t_rel = 0, t_err = 0, lk_cnt = 0, lock_dly = 100;
  logic pend = 1'b0, pend_we = 1'b0, lock_hold0 = 1'b0, lk_arm = 1'b0;
  logic prev_mrst = 1'b0, prev_err = 1'b0;
  logic [6:0] pend_addr = '0;
  logic [5:0] addr_d = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] rom(input logic [5:0] a);
    logic [3:0] e;
    logic [6:0] ad;
    logic [15:0] m, d;
    e  = a[3:0];
    ad = {a[5:4], e, 1'b1};
    m  = (e == 4'd0) ? 16'hFFFF : (e == 4'd1) ? 16'h0000 : ({e, e, e, e} ^ 16'h0A5C);
    d  = (e == 4'd1) ? 16'hABCD : {e, 4'h6, 2'b01, a[5:4], ~e};
    return {ad, m, d};
  endfunction

  function automatic logic [15:0] do_f(input logic [6:0] ad);
    return (ad[4:1] == 4'd0) ? 16'h1234 : ({ad, 9'h15B} ^ 16'hC3C3);
  endfunction

  always @(posedge SYSCLK) cyc++;

  // Models and monitor, all evaluated mid-cycle.
  always @(negedge SYSCLK) begin
    TBL_DATA = rom(addr_d);
    addr_d   = TBL_ADDR;
    if (DRDY) DRDY = 1'b0;
    if (pend) begin
      pend = 1'b0;
      DRDY = 1'b1;
      DO   = pend_we ? 16'h0 : do_f(pend_addr);
    end
    if (DONE) n_done++;
    if (ERR && !prev_err) t_err = cyc;
    prev_err = ERR;
    if (DEN) begin
      n_den++;
      if (DWE) wr_cnt++; else rd_cnt++;
      if (!DWE && rd_cnt == 3) t_den3 = cyc;
      if (!(hang_rd != 0 && !DWE && rd_cnt == hang_rd)) begin
        pend = 1'b1; pend_addr = DADDR; pend_we = DWE;
      end
      chk("mrst_at_den", MMCM_RST, 1);
      if (sb_q.size() == 0) chk("sb_unexp_den", DEN, 0);
      else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("dwe", DWE, e.we);
        chk("daddr", DADDR, e.addr);
        if (e.we) chk("di", DI, e.di);
        if (DWE && DADDR[4:1] == 4'd0) chk("di_mask_ffff", DI, 16'h1234);
        if (DWE && DADDR[4:1] == 4'd1) chk("di_mask_0000", DI, 16'hABCD);
      end
    end
    if (MMCM_RST) begin LOCKED = 1'b0; lk_arm = 1'b1; lk_cnt = 0; end
    else if (lk_arm) begin
      lk_cnt++;
      if (!lock_hold0 && lk_cnt >= lock_dly) begin LOCKED = 1'b1; lk_arm = 1'b0; end
    end
    if (prev_mrst && !MMCM_RST && BUSY) t_rel = cyc;
    prev_mrst = MMCM_RST;
  end

  task automatic do_req(input logic [1:0] m);
    @(negedge SYSCLK);
    REQ = 1'b1; MODE = m; rd_cnt = 0; wr_cnt = 0;
    if (m != 2'd3) begin
      for (int e = 0; e < NREG; e++) begin
        logic [38:0] w;
        sb_t s;
        w = rom({m, 4'(e)});
        s.we = 1'b0; s.addr = w[38:32]; s.di = '0;
        sb_q.push_back(s);
        s.we = 1'b1;
        s.di = (do_f(w[38:32]) & w[31:16]) | (w[15:0] & ~w[31:16]);
        sb_q.push_back(s);
      end
    end
    @(negedge SYSCLK);
    REQ = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge SYSCLK);
    while (BUSY && n < bound) begin @(negedge SYSCLK); n++; end
    chk("idle_bound", BUSY, 0);
    repeat (2) @(negedge SYSCLK);
  endtask

  initial begin
    int d0, den0, n;
    repeat (3) @(negedge SYSCLK);
    chk("rst_busy", BUSY, 0);   chk("rst_den", DEN, 0);
    chk("rst_dwe", DWE, 0);     chk("rst_mrst", MMCM_RST, 0);
    chk("rst_err", ERR, 0);     chk("rst_done", DONE, 0);
    chk("rst_tbl", TBL_ADDR, 0); chk("rst_daddr", DADDR, 0);
    chk("rst_di", DI, 0);
    RSTN = 1'b1;
    repeat (3) @(negedge SYSCLK);

    // full XGA reconfiguration
    d0 = n_done;
    do_req(2'd2);
    chk("xga_busy", BUSY, 1);
    wait_idle(3000);
    chk("xga_done", n_done - d0, 1);
    chk("xga_err", ERR, 0);
    chk("xga_reads", rd_cnt, NREG);
    chk("xga_writes", wr_cnt, NREG);
    chk("xga_sb", sb_q.size(), 0);
    chk("xga_mrst", MMCM_RST, 0);

    // REQ / MODE activity while busy is ignored
    d0 = n_done;
    do_req(2'd1);
    repeat (20) @(negedge SYSCLK);
    REQ = 1'b1; MODE = 2'd3; @(negedge SYSCLK);
    MODE = 2'd0; @(negedge SYSCLK); REQ = 1'b0;
    wait_idle(3000);
    chk("busy_req_done", n_done - d0, 1);
    chk("busy_req_err", ERR, 0);
    chk("busy_req_sb", sb_q.size(), 0);

    // reserved mode rejected
    den0 = n_den;
    do_req(2'd3);
    chk("m3_err", ERR, 1);
    chk("m3_busy", BUSY, 0);
    repeat (5) @(negedge SYSCLK);
    chk("m3_den", n_den - den0, 0);
    chk("m3_mrst", MMCM_RST, 0);

    // DRDY never returned on the third read
    d0 = n_done; hang_rd = 3;
    do_req(2'd2);
    chk("hang_err_clr", ERR, 0);
    wait_idle(1000);
    chk("hang_err", ERR, 1);
    chk("hang_mrst", MMCM_RST, 0);
    chk("hang_done", n_done - d0, 0);
    chk("hang_lat_ok", (t_err - t_den3 >= 254) && (t_err - t_den3 <= 258), 1);
    hang_rd = 0; sb_q.delete();

    // LOCKED stuck low
    d0 = n_done; lock_hold0 = 1'b1;
    do_req(2'd1);
    wait_idle(3000);
    chk("lock_err", ERR, 1);
    chk("lock_done", n_done - d0, 0);
    chk("lock_lat_ok", (t_err - t_rel >= 999) && (t_err - t_rel <= 1003), 1);
    chk("lock_sb", sb_q.size(), 0);
    lock_hold0 = 1'b0;
    d0 = n_done;
    do_req(2'd0);
    chk("lock_err_clr", ERR, 0);
    wait_idle(3000);
    chk("relock_done", n_done - d0, 1);
    chk("relock_err", ERR, 0);

    // reset during WR_WAIT of entry 4
    do_req(2'd2);
    n = 0;
    while (wr_cnt < 5 && n < 2000) begin @(posedge SYSCLK); n++; end
    chk("mid_reach", wr_cnt, 5);
    @(negedge SYSCLK);
    chk("mid_mrst_pre", MMCM_RST, 1);
    RSTN = 1'b0;
    #1;
    chk("mid_den", DEN, 0);
    chk("mid_mrst", MMCM_RST, 0);
    chk("mid_busy", BUSY, 0);
    den0 = n_den;
    repeat (3) @(negedge SYSCLK);
    chk("mid_no_den", n_den - den0, 0);
    sb_q.delete(); pend = 1'b0; DRDY = 1'b0;
    RSTN = 1'b1;
    repeat (3) @(negedge SYSCLK);
    d0 = n_done;
    do_req(2'd0);
    wait_idle(3000);
    chk("restart_done", n_done - d0, 1);
    chk("restart_writes", wr_cnt, NREG);
    chk("restart_sb", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
